// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//
// Passive monitor for a multiplexed, active-low 7-segment display bus. It
// watches the anode enables and the shared segment lines, waits for each
// (AN, HEX0) pair to settle, decodes the glyph shown on each digit, and
// assembles one frame of per-digit character codes. Each completed frame is
// published with a one-cycle valid pulse. The block never drives the bus.
//
// Parameters:
//   SETTLE_CYCLES  - consecutive identical samples needed to accept a pattern (>= 2)
//   TIMEOUT_CYCLES - cycles without an accepted capture before stale rises (>= 2)
//   DIGIT_MASK     - digits that must all be captured to complete a frame
//
// Ports:
//   CLK100MHZ     in   system clock, rising edge
//   RST           in   synchronous active-high reset
//   AN[7:0]       in   anode enables, active-low, asynchronous
//   HEX0[0:6]     in   segments a..g, active-low, bit 0 = a, asynchronous
//   char_codes    out  published frame, nibble i = digit i code
//   frame_valid   out  one-cycle pulse when char_codes updates
//   frame_changed out  one-cycle pulse with frame_valid when the frame differs
//   stale         out  level, no accepted capture within TIMEOUT_CYCLES
//   err_multi     out  one-cycle pulse on an accepted pattern with >1 anode low

module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  DIGIT_MASK     = 8'b00111111
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [7:0]  AN,
    input  logic [0:6]  HEX0,
    output logic [31:0] char_codes,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        stale,
    output logic        err_multi
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [7:0]       an_meta;
    logic [7:0]       an_sync;
    logic [0:6]       hex_meta;
    logic [0:6]       hex_sync;
    logic [14:0]      sample_cur;
    logic [14:0]      sample_prev;
    logic             same_sample;
    logic [CNT_W-1:0] stable_cnt;
    logic             armed;
    logic             accept;
    logic [7:0]       an_low;
    logic             multi_low;
    logic             single_low;
    logic             capture;
    logic             capture_masked;
    logic             frame_done;
    logic [3:0]       glyph_code;
    logic [31:0]      work_codes;
    logic [31:0]      frame_next;
    logic [7:0]       seen;
    logic [31:0]      timeout_cnt;
    logic             timeout_hit;

    // Two-flop synchroniser for the asynchronous display bus. Idles at all
    // ones, which is what a blanked, fully deselected display looks like.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            an_meta  <= 8'hFF;
            an_sync  <= 8'hFF;
            hex_meta <= 7'b1111111;
            hex_sync <= 7'b1111111;
        end else begin
            an_meta  <= AN;
            an_sync  <= an_meta;
            hex_meta <= HEX0;
            hex_sync <= hex_meta;
        end
    end

    assign sample_cur  = {an_sync, hex_sync};
    assign same_sample = (sample_cur == sample_prev);

    // Accept in the cycle the counter steps to its saturation value, which is
    // the SETTLE_CYCLES-th identical sample. Armed limits this to one accept
    // per stable interval.
    assign accept = armed && same_sample && (stable_cnt == SETTLE_PRE);

    // Anode classification: clearing the lowest set bit leaves something
    // only when two or more anodes are active.
    assign an_low         = ~an_sync;
    assign multi_low      = ((an_low & (an_low - 8'd1)) != 8'd0);
    assign single_low     = (an_low != 8'd0) && !multi_low;
    assign capture        = accept && single_low;
    assign capture_masked = capture && ((an_low & DIGIT_MASK) != 8'd0);
    assign frame_done     = capture_masked && ((seen | an_low) == DIGIT_MASK);

    // An acceptance in the threshold cycle resets the counter, so it takes
    // priority over the timeout.
    assign timeout_hit = !capture && (timeout_cnt == TIMEOUT_LAST);

    // Glyph decode; anything not in the table reads as unknown.
    always_comb begin
        glyph_code = 4'hB;
        case (hex_sync)
            7'b0000001: glyph_code = 4'h0;
            7'b1001111: glyph_code = 4'h1;
            7'b1000010: glyph_code = 4'hD;
            7'b0110000: glyph_code = 4'hE;
            7'b1111111: glyph_code = 4'hF;
            default:    glyph_code = 4'hB;
        endcase
    end

    // Frame as it would be published this cycle: working nibbles with the
    // capture being accepted right now merged in, unmasked digits forced blank.
    always_comb begin
        frame_next = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            if (DIGIT_MASK[i]) begin
                if (capture_masked && an_low[i]) begin
                    frame_next[i*4 +: 4] = glyph_code;
                end else begin
                    frame_next[i*4 +: 4] = work_codes[i*4 +: 4];
                end
            end
        end
    end

    // Stability tracking of the synchronised bus.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            sample_prev <= 15'h7FFF;
            stable_cnt  <= '0;
            armed       <= 1'b1;
        end else begin
            sample_prev <= sample_cur;
            if (!same_sample) begin
                stable_cnt <= '0;
                armed      <= 1'b1;
            end else begin
                if (stable_cnt != SETTLE_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                if (accept) begin
                    armed <= 1'b0;
                end
            end
        end
    end

    // Working nibbles, seen set, publication and stale flag. A digit seen
    // twice before the frame completes simply overwrites its nibble.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            work_codes    <= 32'hFFFFFFFF;
            seen          <= 8'h00;
            char_codes    <= 32'hFFFFFFFF;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            stale         <= 1'b1;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (capture_masked && an_low[i]) begin
                    work_codes[i*4 +: 4] <= glyph_code;
                end
            end
            if (frame_done) begin
                char_codes    <= frame_next;
                frame_valid   <= 1'b1;
                frame_changed <= (frame_next != char_codes);
                seen          <= 8'h00;
                stale         <= 1'b0;
            end else if (capture_masked) begin
                seen <= seen | an_low;
            end else if (timeout_hit) begin
                seen  <= 8'h00;
                stale <= 1'b1;
            end
        end
    end

    // Multi-anode patterns are only flagged once they have settled.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            err_multi <= 1'b0;
        end else begin
            err_multi <= accept && multi_low;
        end
    end

    // Cycles since the last single-digit capture, saturating. Blanks and
    // multi-anode patterns do not count as activity.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            timeout_cnt <= 32'd0;
        end else if (capture) begin
            timeout_cnt <= 32'd0;
        end else if (timeout_cnt != 32'hFFFFFFFF) begin
            timeout_cnt <= timeout_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//
// Drives directed and randomised display scans into seg_scan_decoder and
// compares the published frames against a frame-level model of the display
// content kept in this bench.

module tb_seg_scan_decoder;

    localparam int          S    = 4;
    localparam int          T    = 200;
    localparam logic [7:0]  MASK = 8'b00001111;

    localparam logic [0:6] G0 = 7'b0000001;
    localparam logic [0:6] G1 = 7'b1001111;
    localparam logic [0:6] GD = 7'b1000010;
    localparam logic [0:6] GE = 7'b0110000;
    localparam logic [0:6] GB = 7'b1111111;
    localparam logic [0:6] GU = 7'b0100100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [0:6]  hex;
    logic [31:0] char_codes;
    logic        frame_valid;
    logic        frame_changed;
    logic        stale;
    logic        err_multi;

    int checks   = 0;
    int failures = 0;

    int          fv_count  = 0;
    int          em_count  = 0;
    int          fc_orphan = 0;
    logic [31:0] last_codes   = 32'h0;
    logic        last_changed = 1'b0;

    logic [3:0]  m_nib [8];
    logic [7:0]  m_seen;
    logic [31:0] m_pub;
    logic        m_stale;

    seg_scan_decoder #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .DIGIT_MASK    (MASK)
    ) dut (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .AN           (an),
        .HEX0         (hex),
        .char_codes   (char_codes),
        .frame_valid  (frame_valid),
        .frame_changed(frame_changed),
        .stale        (stale),
        .err_multi    (err_multi)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count     <= fv_count + 1;
            last_codes   <= char_codes;
            last_changed <= frame_changed;
        end
        if (frame_changed === 1'b1 && frame_valid !== 1'b1) begin
            fc_orphan <= fc_orphan + 1;
        end
        if (err_multi === 1'b1) begin
            em_count <= em_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [0:6] h, input int cycles);
        an  = a;
        hex = h;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] glyph_to_code(input logic [0:6] g);
        if (g == G0) return 4'h0;
        if (g == G1) return 4'h1;
        if (g == GD) return 4'hD;
        if (g == GE) return 4'hE;
        if (g == GB) return 4'hF;
        return 4'hB;
    endfunction

    function automatic logic [31:0] model_frame();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = MASK[i] ? m_nib[i] : 4'hF;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_nib[i] = 4'hF;
        m_seen  = 8'h00;
        m_pub   = 32'hFFFFFFFF;
        m_stale = 1'b1;
    endtask

    // Show one digit long enough to be captured, then a blank gap, and check
    // what the display content says should have happened.
    task automatic scan_digit(input int idx, input logic [0:6] g, input int hold,
                              input int gap, input string tag);
        int          fv0;
        logic        expect_pub;
        logic [31:0] exp_frame;
        logic        exp_changed;
        logic [7:0]  a;
        fv0         = fv_count;
        expect_pub  = 1'b0;
        exp_frame   = m_pub;
        exp_changed = 1'b0;
        if (MASK[idx]) begin
            m_nib[idx]  = glyph_to_code(g);
            m_seen[idx] = 1'b1;
            if ((m_seen & MASK) == MASK) begin
                expect_pub  = 1'b1;
                exp_frame   = model_frame();
                exp_changed = (exp_frame != m_pub);
                m_pub       = exp_frame;
                m_seen      = 8'h00;
                m_stale     = 1'b0;
            end
        end
        a = ~(8'b1 << idx);
        applyStimulus(a, g, hold);
        applyStimulus(8'hFF, GB, gap);
        checkOutput($sformatf("%s_fv_pulses", tag), fv_count - fv0, {31'd0, expect_pub});
        if (expect_pub) begin
            checkOutput($sformatf("%s_pub_codes", tag), last_codes, exp_frame);
            checkOutput($sformatf("%s_changed", tag), {31'd0, last_changed}, {31'd0, exp_changed});
        end
        checkOutput($sformatf("%s_char_codes", tag), char_codes, m_pub);
        checkOutput($sformatf("%s_stale", tag), {31'd0, stale}, {31'd0, m_stale});
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        applyStimulus(8'hFF, GB, cycles);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [0:6] random_glyph();
        logic [0:6] g;
        case ($urandom_range(0, 5))
            0: g = G0;
            1: g = G1;
            2: g = GD;
            3: g = GE;
            4: g = GB;
            default: g = 7'($urandom);
        endcase
        return g;
    endfunction

    initial begin
        int fv0;
        int em0;
        int order [4];
        int tmp;
        int j;

        rst = 1'b1;
        an  = 8'hFF;
        hex = GB;
        model_reset();

        // Reset state
        applyStimulus(8'hFF, GB, 3);
        checkOutput("reset_char_codes", char_codes, 32'hFFFFFFFF);
        checkOutput("reset_stale", {31'd0, stale}, 32'd1);
        checkOutput("reset_fv", {31'd0, frame_valid}, 32'd0);
        checkOutput("reset_fc", {31'd0, frame_changed}, 32'd0);
        checkOutput("reset_em", {31'd0, err_multi}, 32'd0);
        rst = 1'b0;
        applyStimulus(8'hFF, GB, 10);
        checkOutput("post_reset_fv_count", fv_count, 0);

        // Clean frame
        scan_digit(3, GD, 20, 5, "clean3");
        scan_digit(2, GE, 20, 5, "clean2");
        scan_digit(1, G1, 20, 5, "clean1");
        scan_digit(0, G0, 20, 5, "clean0");
        checkOutput("clean_value", char_codes, 32'hFFFFDE10);

        // Identical frame, then shifted content
        scan_digit(3, GD, 20, 5, "same3");
        scan_digit(2, GE, 20, 5, "same2");
        scan_digit(1, G1, 20, 5, "same1");
        scan_digit(0, G0, 20, 5, "same0");
        scan_digit(3, GE, 20, 5, "shift3");
        scan_digit(2, G1, 20, 5, "shift2");
        scan_digit(1, G0, 20, 5, "shift1");
        scan_digit(0, GD, 20, 5, "shift0");
        checkOutput("shift_value", char_codes, 32'hFFFFE10D);

        // Glitch rejection: only digit 0 missing, so any glitch capture
        // would publish early.
        scan_digit(3, G0, 20, 5, "pre3");
        scan_digit(2, G0, 20, 5, "pre2");
        scan_digit(1, G0, 20, 5, "pre1");
        fv0 = fv_count;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(8'hFE, (k % 2 == 0) ? GD : GE, 2);
        end
        checkOutput("glitch_no_publish", fv_count - fv0, 0);
        scan_digit(0, G1, 20, 5, "glitch0");
        checkOutput("glitch_value", char_codes, 32'hFFFF0001);

        // Two anodes low
        fv0 = fv_count;
        em0 = em_count;
        applyStimulus(8'hFC, G1, 10);
        applyStimulus(8'hFF, GB, 5);
        checkOutput("multi_err_pulses", em_count - em0, 1);
        checkOutput("multi_no_publish", fv_count - fv0, 0);
        checkOutput("multi_char_codes", char_codes, m_pub);

        // Timeout clears the partial frame
        scan_digit(0, G0, 20, 5, "to0");
        scan_digit(1, G1, 20, 5, "to1");
        scan_digit(2, GE, 20, 5, "to2");
        applyStimulus(8'hFF, GB, 150);
        checkOutput("timeout_not_yet", {31'd0, stale}, 32'd0);
        applyStimulus(8'hFF, GB, 70);
        checkOutput("timeout_stale", {31'd0, stale}, 32'd1);
        m_seen  = 8'h00;
        m_stale = 1'b1;
        scan_digit(3, GD, 20, 5, "to_lone3");
        scan_digit(3, GD, 20, 5, "to_full3");
        scan_digit(2, GE, 20, 5, "to_full2");
        scan_digit(1, G1, 20, 5, "to_full1");
        scan_digit(0, G0, 20, 5, "to_full0");

        // Unknown glyph and masked digit
        scan_digit(3, G0, 20, 5, "unk3");
        scan_digit(7, GE, 20, 5, "mask7");
        scan_digit(2, G0, 20, 5, "unk2");
        scan_digit(1, GU, 20, 5, "unk1");
        scan_digit(0, G0, 20, 5, "unk0");
        checkOutput("unknown_value", char_codes, 32'hFFFF00B0);

        // Reset mid-frame
        scan_digit(0, G1, 20, 5, "mid0");
        scan_digit(1, G1, 20, 5, "mid1");
        do_reset(3);
        checkOutput("mid_reset_codes", char_codes, 32'hFFFFFFFF);
        checkOutput("mid_reset_stale", {31'd0, stale}, 32'd1);
        scan_digit(2, G1, 20, 5, "after2");
        scan_digit(3, G1, 20, 5, "after3");
        scan_digit(0, GE, 20, 5, "fresh0");
        scan_digit(1, GD, 20, 5, "fresh1");
        scan_digit(2, G0, 20, 5, "fresh2");
        scan_digit(3, G1, 20, 5, "fresh3");

        // Randomised scans
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) order[i] = i;
            for (int i = 3; i > 0; i--) begin
                j        = $urandom_range(0, i);
                tmp      = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    scan_digit($urandom_range(0, 7), random_glyph(),
                               $urandom_range(10, 24), $urandom_range(3, 8),
                               $sformatf("rnd%0d_extra%0d", f, i));
                end
                scan_digit(order[i], random_glyph(), $urandom_range(10, 24),
                           $urandom_range(3, 8), $sformatf("rnd%0d_d%0d", f, order[i]));
            end
        end

        checkOutput("changed_without_valid", fc_orphan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed, active-low 7-segment display bus (anode select plus shared segment lines), as driven by the board's scanning display drivers.
- Decodes the glyph shown on each digit and assembles one frame of per-digit character codes.
- Publishes each frame with a one-cycle valid pulse.
- Used as an on-chip monitor/self-check of display content and as the capture side for display-driven test benches.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical samples required before an (AN, HEX0) pair is accepted; minimum 2.
- TIMEOUT_CYCLES, 1000000: cycles without any accepted capture before stale is raised; minimum 2.
- DIGIT_MASK, 8'b00111111: digits that must all be captured to complete a frame; bit i corresponds to AN[i].

Ports:
- CLK100MHZ, input, 1: system clock; all logic on its rising edge.
- RST, input, 1: synchronous, active-high reset.
- AN, input, 8: anode enables, active-low; asynchronous to the block.
- HEX0, input, [0:6]: segments a..g, active-low; bit 0 = a; asynchronous to the block.
- char_codes, output, 32: published frame; nibble i = digit i code.
- frame_valid, output, 1: one-cycle pulse when char_codes is updated.
- frame_changed, output, 1: one-cycle pulse coincident with frame_valid when the new char_codes differs from the previous value.
- stale, output, 1: level; no accepted capture within TIMEOUT_CYCLES.
- err_multi, output, 1: one-cycle pulse on an accepted pattern with more than one AN bit low.

Behaviour:
- Input synchronisation:
  - AN and HEX0 pass through a 2-flop synchroniser.
  - All later logic uses the synchronised values.
  - Total input-to-decision latency: 2 + SETTLE_CYCLES cycles.
- Stability counter:
  - Compares the current synchronised 15-bit {AN, HEX0} with the previous sample.
  - On a mismatch the counter clears to 0 and the armed flag is set.
  - On a match the counter increments, saturating at SETTLE_CYCLES-1.
- Acceptance:
  - Occurs in the cycle the counter reaches SETTLE_CYCLES-1 while armed; armed then clears.
  - At most one acceptance per stable interval.
  - A pattern held indefinitely is accepted once.
- Accepted AN classes:
  - Exactly one bit low (digit i): decode HEX0 and write the code into working nibble i. If DIGIT_MASK[i] is 1, set seen[i]. If DIGIT_MASK[i] is 0, the write is discarded and seen is unchanged. The timeout counter clears in every case.
  - All bits high (inter-digit blank): no capture, no error, timeout counter not cleared.
  - Two or more bits low: pulse err_multi, no capture, timeout counter not cleared.
- Decode table (HEX0[0:6] to code):
  - 0000001 → 4'h0 ('0')
  - 1001111 → 4'h1 ('1')
  - 1000010 → 4'hD ('d')
  - 0110000 → 4'hE ('E')
  - 1111111 → 4'hF (blank)
  - anything else → 4'hB (unknown)
- Frame publication:
  - When the acceptance that makes (seen | new bit) == DIGIT_MASK occurs, the next cycle copies the working nibbles (including the new one) into char_codes and pulses frame_valid.
  - In that same cycle, frame_changed pulses if the new value differs from the old char_codes.
  - seen clears to 0 on the publication cycle.
  - Digits outside DIGIT_MASK are published as 4'hF.
  - A digit captured twice before the frame completes: the latest code wins; no error.
- Timeout:
  - The 32-bit counter increments each cycle, saturating.
  - When it reaches TIMEOUT_CYCLES-1: stale is set and seen clears.
  - stale clears in the cycle a frame is published.
  - If an acceptance and the timeout threshold occur in the same cycle, the acceptance wins: the counter clears and stale is not set.
- Reset (RST=1 at a clock edge):
  - char_codes = 32'hFFFFFFFF; working nibbles = 4'hF.
  - frame_valid = 0, frame_changed = 0, err_multi = 0, stale = 1.
  - Stability counter = 0, armed = 1, seen = 0, timeout counter = 0.
  - Synchroniser flops = all ones.
  - Reset mid-frame discards partial captures; nothing is published.
- The block never drives the display bus; it is a pure observer.

Test Plan:
Bench parameters: SETTLE_CYCLES=4, TIMEOUT_CYCLES=200, DIGIT_MASK=8'b00001111.
- Reset check: hold RST 3 cycles → char_codes=32'hFFFFFFFF, stale=1, no pulses.
- Clean frame: scan AN=F7/HEX 1000010, FB/0110000, FD/1001111, FE/0000001, each held 20 cycles with 5-cycle all-high gaps. Required: exactly one frame_valid, 1 cycle after the 4th acceptance; char_codes=32'hFFFFDE10; frame_changed=1; stale=0.
- Repeat identical frame → frame_valid=1, frame_changed=0. Then shift content (digit3='E', digit2='1', digit1='0', digit0='d') → char_codes=32'hFFFFE10D, frame_changed=1.
- Glitch rejection: toggle HEX0 every 2 cycles for 30 cycles on AN=FE, then hold 1001111 → single capture of 4'h1 only. Hold AN=FC for 10 cycles → one err_multi pulse, no capture.
- Timeout: capture digits 0..2, then idle AN=FF for 200 cycles → stale rises at cycle 200 and seen clears; supplying only digit 3 must not publish; a full 4-digit scan publishes and clears stale.
- Unknown/masked: digit1 pattern 0100100 → nibble 4'hB. Capture on AN=7F (digit 7, unmasked) → no effect on seen or char_codes. Assert RST mid-frame → no frame_valid until a fresh full scan.
